// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every N-bit vector for HOLD cycles, captures y, and
// checks it against an expected table. Define SWEEP_GRAY_EN to sweep in Gray-code order.
module truth_table_sweeper #(
    parameter int unsigned N    = 3,
    parameter int unsigned HOLD = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2**N-1:0]  expected,
    input  logic             y,
    output logic [N-1:0]     x,
    output logic             busy,
    output logic             done,
    output logic [2**N-1:0]  table_out,
    output logic             pass,
    output logic [N:0]       mismatch_count,
    output logic [N-1:0]     first_fail_idx
);

    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    step_q, step_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [N-1:0]    x_q, x_d;
    logic [2**N-1:0] table_q, table_d;
    logic [N:0]      mism_q, mism_d;
    logic [N-1:0]    ffi_q, ffi_d;
    logic            pass_q, pass_d;

    logic hold_last, step_last, launch;

    function automatic logic [N-1:0] vec(input logic [N-1:0] s);
`ifdef SWEEP_GRAY_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

    assign hold_last = (hold_q == HW'(HOLD - 1));
    assign step_last = (step_q == {N{1'b1}});
    assign launch    = start && (state_q != StDrive);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            hold_q  <= '0;
            x_q     <= '0;
            table_q <= '0;
            mism_q  <= '0;
            ffi_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            x_q     <= x_d;
            table_q <= table_d;
            mism_q  <= mism_d;
            ffi_q   <= ffi_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StDrive;
            StDrive: if (hold_last && step_last) state_d = StDone;
            StDone:  if (start) state_d = StDrive;
            default: state_d = StIdle;
        endcase
    end

    // x_q always equals vec(step_q) while driving, so it doubles as the table index.
    always_comb begin
        step_d  = step_q;
        hold_d  = hold_q;
        x_d     = x_q;
        table_d = table_q;
        mism_d  = mism_q;
        ffi_d   = ffi_q;
        pass_d  = pass_q;
        if (launch) begin
            step_d  = '0;
            hold_d  = '0;
            x_d     = vec('0);
            table_d = '0;
            mism_d  = '0;
            ffi_d   = '0;
            pass_d  = 1'b0;
        end else if (state_q == StDrive) begin
            if (hold_last) begin
                table_d[x_q] = y;
                if (y != expected[x_q]) begin
                    mism_d = mism_q + 1'b1;
                    if (mism_q == '0) ffi_d = x_q;
                end
                if (step_last) begin
                    x_d    = '0;
                    pass_d = (mism_d == '0);
                end else begin
                    step_d = step_q + 1'b1;
                    hold_d = '0;
                    x_d    = vec(step_q + 1'b1);
                end
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_comb begin
        busy           = (state_q == StDrive);
        done           = (state_q == StDone);
        x              = x_q;
        table_out      = table_q;
        pass           = pass_q;
        mismatch_count = mism_q;
        first_fail_idx = ffi_q;
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: N=3/HOLD=20 XOR sweeps driven from a record table with a
// result scoreboard, plus hand-written restart, mid-sweep reset and N=2/HOLD=1 sequences.
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] expected = 8'h00;
    logic       y;
    logic [2:0] x;
    logic       busy, done, pass;
    logic [7:0] table_out;
    logic [3:0] mismatch_count;
    logic [2:0] first_fail_idx;

    logic       start2 = 1'b0;
    logic [3:0] expected2 = 4'b1000;
    logic       y2;
    logic [1:0] x2;
    logic       busy2, done2, pass2;
    logic [3:0] table2;
    logic [2:0] mism2;
    logic [1:0] ffi2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign y  = ^x;
    assign y2 = &x2;

    truth_table_sweeper #(.N(3), .HOLD(20)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .y(y), .x(x),
        .busy(busy), .done(done), .table_out(table_out), .pass(pass),
        .mismatch_count(mismatch_count), .first_fail_idx(first_fail_idx)
    );

    truth_table_sweeper #(.N(2), .HOLD(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .expected(expected2), .y(y2), .x(x2),
        .busy(busy2), .done(done2), .table_out(table2), .pass(pass2),
        .mismatch_count(mism2), .first_fail_idx(ffi2)
    );

    typedef struct {
        logic [7:0] exp_tab;
        logic [7:0] tab;
        logic [3:0] mc;
        logic [2:0] ffi;
        logic       pass;
    } rec_t;

    rec_t recs[4];
    rec_t sb[$];

    function automatic int gvec(input int s);
`ifdef SWEEP_GRAY_EN
        return s ^ (s >> 1);
`else
        return s;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Pulse start, follow x through the sweep, then score the results against the queue head.
    task automatic run_sweep(input int idx, input bit repulse);
        int c;
        bit got;
        rec_t r;
        expected = recs[idx].exp_tab;
        sb.push_back(recs[idx]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("e0_busy", busy, 1);
        check("e0_done", done, 0);
        check("e0_x", x, 0);
        check("e0_cleared", {table_out, mismatch_count, first_fail_idx, pass}, 0);
        c = 0;
        got = 0;
        while (c < 400 && !got) begin
            start = (repulse && c == 49);
            @(posedge clk); #1;
            c++;
            if (done) got = 1;
            else if (c % 20 == 0 || c % 20 == 19) check("x_seq", x, gvec(c / 20));
        end
        start = 1'b0;
        if (!got) begin
            check("done_timeout", 0, 1);
        end else begin
            check("latency", c, 160);
            check("done_busy", busy, 0);
            check("done_x", x, 0);
            if (sb.size() == 0) begin
                check("sb_empty", 0, 1);
            end else begin
                r = sb.pop_front();
                check("table_out", table_out, r.tab);
                check("mismatch_count", mismatch_count, r.mc);
                check("first_fail_idx", first_fail_idx, r.ffi);
                check("pass", pass, r.pass);
            end
        end
    endtask

    initial begin
        int c;
        bit got;
        recs[0] = '{8'h96, 8'h96, 4'd0, 3'd0, 1'b1};
        recs[1] = '{8'hB6, 8'h96, 4'd1, 3'd5, 1'b0};
        recs[2] = '{8'h97, 8'h96, 4'd1, 3'd0, 1'b0};
        recs[3] = '{8'h69, 8'h96, 4'd8, 3'd0, 1'b0};

        #12;
        check("rst_outputs", {x, busy, done, table_out, pass, mismatch_count, first_fail_idx}, 0);
        check("rst_outputs2", {x2, busy2, done2, table2, pass2, mism2, ffi2}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First sweep from IDLE with a start re-pulse mid-sweep; the rest restart from DONE.
        run_sweep(0, 1'b1);
        for (int i = 1; i < 4; i++) run_sweep(i, 1'b0);
        run_sweep(0, 1'b0);

        // Mid-sweep reset while x==3, asserted between clock edges.
        expected = 8'h69;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while (c < 200 && x != 3'd3) begin
            @(posedge clk); #1;
            c++;
        end
        check("reach_x3", x, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst", {x, busy, done, table_out, mismatch_count, first_fail_idx, pass}, 0);
        #7;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_rst", {busy, done, x}, 0);
        run_sweep(0, 1'b0);

        // N=2, HOLD=1 AND gate: a new vector every cycle.
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        check("h1_e0_x", x2, 0);
        check("h1_e0_busy", busy2, 1);
        c = 0;
        got = 0;
        while (c < 20 && !got) begin
            @(posedge clk); #1;
            c++;
            if (done2) got = 1;
            else check("h1_x_seq", x2, gvec(c));
        end
        check("h1_latency", c, 4);
        check("h1_table", table2, 4'b1000);
        check("h1_pass", pass2, 1);
        check("h1_mism", mism2, 0);
        check("h1_x_done", x2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
